// File: rtl/isp_tpg_if.sv
// Pixel stream handshake between the test-pattern source and its consumer.
// Valid/ready: a pixel moves on every clk edge where pixel_valid && pixel_ready;
// while pixel_valid is high and pixel_ready is low the source holds data, sof and eol.
interface isp_tpg_if;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [23:0] pixel_data_out;
   logic        sof;
   logic        eol;

   modport master (
      output pixel_valid,
      output pixel_data_out,
      output sof,
      output eol,
      input  pixel_ready
   );

   modport slave (
      input  pixel_valid,
      input  pixel_data_out,
      input  sof,
      input  eol,
      output pixel_ready
   );
endinterface

// File: rtl/isp_tpg.sv
// Raster test-pattern generator with periodic hot/dead pixel injection.
// All stream outputs are registered from the next-state values of the counters.
module isp_tpg #(
   parameter int H_DISP        = 720,
   parameter int V_DISP        = 480,
   parameter int H_BLANK       = 16,
   parameter int V_BLANK       = 64,
   parameter int DEFECT_PERIOD = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        tpg_en,
   input  logic [1:0]  pattern_sel,
   input  logic        defect_en,
   isp_tpg_if.master   pix,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   localparam int DW    = $clog2(DEFECT_PERIOD);
   localparam int HW0   = ($clog2(H_DISP) > 8) ? $clog2(H_DISP) : 8;
   localparam int HW    = (HW0 > DW) ? HW0 : DW;
   localparam int VW0   = ($clog2(V_DISP) > 4) ? $clog2(V_DISP) : 4;
   localparam int VW    = (VW0 > DW) ? VW0 : DW;
   localparam int BAR_W = H_DISP / 8;
   localparam int SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int BMAX  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int CW    = $clog2(BMAX + 1);

   localparam logic [HW-1:0] H_LAST   = HW'(H_DISP - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_DISP - 1);
   localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);
   localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VB_LAST  = CW'(V_BLANK - 1);
   localparam logic [DW-1:0] DEF_POS  = DW'(DEFECT_PERIOD / 2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2,
      S_VBLANK = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [HW-1:0] h_cnt, h_nxt;
   logic [VW-1:0] v_cnt, v_nxt;
   logic [SW-1:0] bar_sub, sub_nxt;
   logic [2:0]    bar_idx, idx_nxt;
   logic [CW-1:0] blk_cnt, blk_nxt;
   logic          frame_par, par_nxt;
   logic [1:0]    pat_q, pat_nxt;
   logic          def_q, def_nxt;
   logic          xfer;
   logic          active_nxt;
   logic [23:0]   pat_pix;
   logic [23:0]   pix_nxt;
   logic          defect_hit;

   assign xfer      = pix.pixel_valid && pix.pixel_ready;
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      sub_nxt   = bar_sub;
      idx_nxt   = bar_idx;
      blk_nxt   = blk_cnt;
      par_nxt   = frame_par;
      pat_nxt   = pat_q;
      def_nxt   = def_q;
      case (state)
         S_IDLE: begin
            if (tpg_en) begin
               state_nxt = S_ACTIVE;
               pat_nxt   = pattern_sel;
               def_nxt   = defect_en;
               h_nxt     = '0;
               v_nxt     = '0;
               sub_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         S_ACTIVE: begin
            if (xfer) begin
               if (h_cnt == H_LAST) begin
                  state_nxt = S_HBLANK;
                  h_nxt     = '0;
                  sub_nxt   = '0;
                  idx_nxt   = '0;
                  blk_nxt   = '0;
               end else begin
                  h_nxt = h_cnt + 1'b1;
                  // Bar index advances every BAR_W pixels without a divider.
                  if (bar_sub == SUB_LAST) begin
                     sub_nxt = '0;
                     idx_nxt = bar_idx + 3'd1;
                  end else begin
                     sub_nxt = bar_sub + 1'b1;
                  end
               end
            end
         end
         S_HBLANK: begin
            if (blk_cnt == HB_LAST) begin
               blk_nxt = '0;
               if (v_cnt != V_LAST) begin
                  v_nxt     = v_cnt + 1'b1;
                  state_nxt = S_ACTIVE;
               end else begin
                  state_nxt = S_VBLANK;
               end
            end else begin
               blk_nxt = blk_cnt + 1'b1;
            end
         end
         S_VBLANK: begin
            if (blk_cnt == VB_LAST) begin
               blk_nxt = '0;
               par_nxt = ~frame_par;
               v_nxt   = '0;
               h_nxt   = '0;
               sub_nxt = '0;
               idx_nxt = '0;
               if (tpg_en) begin
                  state_nxt = S_ACTIVE;
                  pat_nxt   = pattern_sel;
                  def_nxt   = defect_en;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               blk_nxt = blk_cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pat_pix = 24'h808080;
      case (pat_nxt)
         2'd0: begin
            case (idx_nxt)
               3'd0:    pat_pix = 24'hFFFFFF;
               3'd1:    pat_pix = 24'hFFFF00;
               3'd2:    pat_pix = 24'h00FFFF;
               3'd3:    pat_pix = 24'h00FF00;
               3'd4:    pat_pix = 24'hFF00FF;
               3'd5:    pat_pix = 24'hFF0000;
               3'd6:    pat_pix = 24'h0000FF;
               default: pat_pix = 24'h000000;
            endcase
         end
         2'd1:    pat_pix = {h_nxt[7:0], h_nxt[7:0], h_nxt[7:0]};
         2'd2:    pat_pix = (h_nxt[3] ^ v_nxt[3]) ? 24'hFFFFFF : 24'h000000;
         default: pat_pix = 24'h808080;
      endcase
   end

   // Defect grid sits at the centre of each DEFECT_PERIOD square; polarity alternates per frame.
   assign defect_hit = def_nxt && (h_nxt[DW-1:0] == DEF_POS) && (v_nxt[DW-1:0] == DEF_POS);
   assign pix_nxt    = defect_hit ? (par_nxt ? 24'h000000 : 24'hFFFFFF) : pat_pix;
   assign active_nxt = (state_nxt == S_ACTIVE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         h_cnt     <= '0;
         v_cnt     <= '0;
         bar_sub   <= '0;
         bar_idx   <= '0;
         blk_cnt   <= '0;
         frame_par <= 1'b0;
         pat_q     <= '0;
         def_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         h_cnt     <= h_nxt;
         v_cnt     <= v_nxt;
         bar_sub   <= sub_nxt;
         bar_idx   <= idx_nxt;
         blk_cnt   <= blk_nxt;
         frame_par <= par_nxt;
         pat_q     <= pat_nxt;
         def_q     <= def_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pix.pixel_valid    <= 1'b0;
         pix.pixel_data_out <= '0;
         pix.sof            <= 1'b0;
         pix.eol            <= 1'b0;
         busy               <= 1'b0;
      end else begin
         pix.pixel_valid    <= active_nxt;
         pix.pixel_data_out <= active_nxt ? pix_nxt : 24'h000000;
         pix.sof            <= active_nxt && (h_nxt == '0) && (v_nxt == '0);
         pix.eol            <= active_nxt && (h_nxt == H_LAST);
         busy               <= (state_nxt != S_IDLE);
      end
   end

endmodule
